// File: rtl/gpr_wb_ctrl.sv
// gpr_wb_ctrl: serialises ALU/JAL/load-response writes onto the single GPR write port.
// Build option: define GPR_WB_BYPASS_EN to let a request skip an empty FIFO (latency 1).

module gpr_wb_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int LD_DEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  input  logic [4:0]  alu_reg,
  input  logic [31:0] alu_data,
  input  logic        alu_set,
  input  logic        jal_valid,
  input  logic [29:0] pc_plus,
  input  logic        ld_issue,
  input  logic [4:0]  ld_reg,
  input  logic        ld_resp_valid,
  input  logic [31:0] ld_resp_data,
  output logic        wr_en,
  output logic [4:0]  wr_reg,
  output logic [31:0] wr_data,
  output logic [31:0] pending,
  output logic        stall,
  output logic        err
);

  localparam int FPW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam int LPW = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1;
  localparam int LCW = $clog2(LD_DEPTH + 1);

  logic [4:0]            fifo_reg  [FIFO_DEPTH];
  logic [31:0]           fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_vld;
  logic [FPW-1:0]        fifo_rd, fifo_wr;
  logic [FCW-1:0]        fifo_cnt;

  logic [4:0]            tag_reg [LD_DEPTH];
  logic [LD_DEPTH-1:0]   tag_vld;
  logic [LPW-1:0]        tag_rd, tag_wr;
  logic [LCW-1:0]        tag_cnt;

  logic        req_valid, req_live;
  logic [4:0]  req_reg;
  logic [31:0] req_data;
  logic        tag_empty, tag_full, ld_pop, ld_push, ld_wr;
  logic [4:0]  ld_head;
  logic        fifo_empty, fifo_full, fifo_pop, fifo_push;
  logic        bypass, err_set;
  logic [31:0] pend_c;

  function automatic logic [FPW-1:0] fifo_next(input logic [FPW-1:0] p);
    return (p == FPW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [LPW-1:0] tag_next(input logic [LPW-1:0] p);
    return (p == LPW'(LD_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // JAL wins a same-cycle collision; the ALU request is dropped and flagged.
  assign req_valid = jal_valid | alu_valid;
  assign req_reg   = jal_valid ? 5'd31 : alu_reg;
  assign req_data  = jal_valid ? {pc_plus, 2'b00}
                   : (alu_set ? {31'b0, alu_data[31]} : alu_data);
  assign req_live  = req_valid && (req_reg != 5'd0);

  assign tag_empty = (tag_cnt == '0);
  assign tag_full  = (tag_cnt == LCW'(LD_DEPTH));
  assign ld_pop    = ld_resp_valid && !tag_empty;
  assign ld_head   = tag_reg[tag_rd];
  assign ld_wr     = ld_pop && (ld_head != 5'd0);
  assign ld_push   = ld_issue && (!tag_full || ld_pop);

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == FCW'(FIFO_DEPTH));
  assign fifo_pop   = !fifo_empty && !ld_wr;

`ifdef GPR_WB_BYPASS_EN
  assign bypass = req_live && fifo_empty && !ld_resp_valid;
`else
  assign bypass = 1'b0;
`endif

  assign fifo_push = req_live && !bypass && (!fifo_full || fifo_pop);

  assign err_set = (jal_valid && alu_valid)
                 || (ld_resp_valid && tag_empty)
                 || (ld_issue && tag_full && !ld_pop)
                 || (req_live && !bypass && fifo_full && !fifo_pop);

  assign stall = (fifo_cnt >= FCW'(FIFO_DEPTH - 1)) || tag_full;

  always_comb begin
    pend_c = '0;
    for (int i = 0; i < FIFO_DEPTH; i++)
      if (fifo_vld[i]) pend_c[fifo_reg[i]] = 1'b1;
    for (int i = 0; i < LD_DEPTH; i++)
      if (tag_vld[i]) pend_c[tag_reg[i]] = 1'b1;
    if (wr_en) pend_c[wr_reg] = 1'b1;
    pend_c[0] = 1'b0;
  end

  assign pending = pend_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en    <= 1'b0;
      wr_reg   <= '0;
      wr_data  <= '0;
      err      <= 1'b0;
      fifo_vld <= '0;
      fifo_rd  <= '0;
      fifo_wr  <= '0;
      fifo_cnt <= '0;
      tag_vld  <= '0;
      tag_rd   <= '0;
      tag_wr   <= '0;
      tag_cnt  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_reg[i]  <= '0;
        fifo_data[i] <= '0;
      end
      for (int i = 0; i < LD_DEPTH; i++) tag_reg[i] <= '0;
    end else begin
      wr_en <= ld_wr | fifo_pop | bypass;
      if (ld_wr) begin
        wr_reg  <= ld_head;
        wr_data <= ld_resp_data;
      end else if (fifo_pop) begin
        wr_reg  <= fifo_reg[fifo_rd];
        wr_data <= fifo_data[fifo_rd];
      end else if (bypass) begin
        wr_reg  <= req_reg;
        wr_data <= req_data;
      end

      // Push is applied after pop so a full-queue pop+push reuses the slot.
      if (fifo_pop) begin
        fifo_vld[fifo_rd] <= 1'b0;
        fifo_rd           <= fifo_next(fifo_rd);
      end
      if (fifo_push) begin
        fifo_vld[fifo_wr]  <= 1'b1;
        fifo_reg[fifo_wr]  <= req_reg;
        fifo_data[fifo_wr] <= req_data;
        fifo_wr            <= fifo_next(fifo_wr);
      end
      if (fifo_push != fifo_pop)
        fifo_cnt <= fifo_push ? fifo_cnt + 1'b1 : fifo_cnt - 1'b1;

      if (ld_pop) begin
        tag_vld[tag_rd] <= 1'b0;
        tag_rd          <= tag_next(tag_rd);
      end
      if (ld_push) begin
        tag_vld[tag_wr] <= 1'b1;
        tag_reg[tag_wr] <= ld_reg;
        tag_wr          <= tag_next(tag_wr);
      end
      if (ld_push != ld_pop)
        tag_cnt <= ld_push ? tag_cnt + 1'b1 : tag_cnt - 1'b1;

      if (err_set) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gpr_wb_ctrl.sv
// Bench for gpr_wb_ctrl: directed vector table, hand-written corner sequences and
// randomized traffic checked against a queue-based reference model.

module tb_gpr_wb_ctrl;

  localparam int FD = 4;
  localparam int LD = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_valid, alu_set, jal_valid, ld_issue, ld_resp_valid;
  logic [4:0]  alu_reg, ld_reg;
  logic [31:0] alu_data, ld_resp_data;
  logic [29:0] pc_plus;
  logic        wr_en, stall, err;
  logic [4:0]  wr_reg;
  logic [31:0] wr_data, pending;

  gpr_wb_ctrl #(.FIFO_DEPTH(FD), .LD_DEPTH(LD)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_set(alu_set),
    .jal_valid(jal_valid), .pc_plus(pc_plus),
    .ld_issue(ld_issue), .ld_reg(ld_reg),
    .ld_resp_valid(ld_resp_valid), .ld_resp_data(ld_resp_data),
    .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
    .pending(pending), .stall(stall), .err(err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_miss = 0;

  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  ent_t        m_fifo[$];
  logic [4:0]  m_tags[$];
  logic        m_en, m_err;
  logic [4:0]  m_reg;
  logic [31:0] m_data;

  typedef struct packed {
    logic        alu_v;
    logic [4:0]  alu_r;
    logic [31:0] alu_d;
    logic        alu_s;
    logic        jal_v;
    logic [29:0] pc;
    logic        ld_i;
    logic [4:0]  ld_r;
    logic        ld_rv;
    logic [31:0] ld_d;
    logic        e_en;
    logic [4:0]  e_reg;
    logic [31:0] e_data;
    logic [31:0] e_pend;
    logic        e_stall;
    logic        e_err;
  } vec_t;

  vec_t tbl [14];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_fifo.delete();
    m_tags.delete();
    m_en = 1'b0;
    m_reg = '0;
    m_data = '0;
    m_err = 1'b0;
  endfunction

  // One clock of the write-side rules, applied to the current inputs.
  function automatic void model_step();
    bit          wrote = 0;
    bit          live;
    bit          fifo_was_empty = (m_fifo.size() == 0);
    logic [4:0]  wreg = '0, rr, t;
    logic [31:0] wdata = '0, rd;
    ent_t        e;
    if (ld_resp_valid) begin
      if (m_tags.size() == 0) m_err = 1'b1;
      else begin
        t = m_tags.pop_front();
        if (t != 5'd0) begin wrote = 1; wreg = t; wdata = ld_resp_data; end
      end
    end
    if (ld_issue) begin
      if (m_tags.size() == LD) m_err = 1'b1;
      else m_tags.push_back(ld_reg);
    end
    if (jal_valid && alu_valid) m_err = 1'b1;
    rr = jal_valid ? 5'd31 : alu_reg;
    rd = jal_valid ? {pc_plus, 2'b00} : (alu_set ? {31'b0, alu_data[31]} : alu_data);
    live = (jal_valid || alu_valid) && (rr != 5'd0);
    if (!wrote && m_fifo.size() > 0) begin
      e = m_fifo.pop_front();
      wrote = 1; wreg = e.r; wdata = e.d;
    end
`ifdef GPR_WB_BYPASS_EN
    if (live && !wrote && fifo_was_empty && !ld_resp_valid) begin
      wrote = 1; wreg = rr; wdata = rd; live = 0;
    end
`else
    if (fifo_was_empty) wrote = wrote;
`endif
    if (live) begin
      if (m_fifo.size() == FD) m_err = 1'b1;
      else begin e.r = rr; e.d = rd; m_fifo.push_back(e); end
    end
    m_en = wrote;
    if (wrote) begin m_reg = wreg; m_data = wdata; end
  endfunction

  function automatic logic [31:0] model_pend();
    logic [31:0] p = '0;
    foreach (m_fifo[i]) p[m_fifo[i].r] = 1'b1;
    foreach (m_tags[i]) p[m_tags[i]] = 1'b1;
    if (m_en) p[m_reg] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  function automatic void check_model();
    chk("wr_en",   32'(wr_en),  32'(m_en));
    chk("wr_reg",  32'(wr_reg), 32'(m_reg));
    chk("wr_data", wr_data, m_data);
    chk("pending", pending, model_pend());
    chk("stall",   32'(stall),  32'((m_fifo.size() >= FD - 1) || (m_tags.size() == LD)));
    chk("err",     32'(err),    32'(m_err));
  endfunction

  function automatic void clr_in();
    alu_valid = 0; alu_reg = '0; alu_data = '0; alu_set = 0;
    jal_valid = 0; pc_plus = '0;
    ld_issue = 0; ld_reg = '0; ld_resp_valid = 0; ld_resp_data = '0;
  endfunction

  task automatic step_chk();
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    clr_in();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_wr_en",   32'(wr_en),  32'h0);
    chk("rst_wr_reg",  32'(wr_reg), 32'h0);
    chk("rst_wr_data", wr_data,     32'h0);
    chk("rst_pending", pending,     32'h0);
    chk("rst_stall",   32'(stall),  32'h0);
    chk("rst_err",     32'(err),    32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_step();
    @(posedge clk);
    #1;
  endtask

  function automatic void rand_inputs(input int perr);
    alu_valid    = ($urandom_range(0, 99) < 50);
    alu_reg      = 5'($urandom_range(0, 12));
    alu_data     = $urandom;
    alu_set      = ($urandom_range(0, 3) == 0);
    jal_valid    = alu_valid ? ($urandom_range(0, 99) < perr) : ($urandom_range(0, 99) < 10);
    pc_plus      = 30'($urandom);
    ld_issue     = (m_tags.size() < LD) ? ($urandom_range(0, 99) < 25) : ($urandom_range(0, 99) < perr);
    ld_reg       = 5'($urandom_range(0, 12));
    ld_resp_valid = (m_tags.size() > 0) ? ($urandom_range(0, 99) < 30) : ($urandom_range(0, 99) < perr);
    ld_resp_data = $urandom;
  endfunction

  initial begin
    // alu_v alu_r alu_d alu_s jal_v pc ld_i ld_r ld_rv ld_d | en reg data pend stall err
`ifdef GPR_WB_BYPASS_EN
    tbl[0]  = '{1'b1, 5'd5, 32'h1234_5678, 1'b0, 1'b0, 30'h0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b1, 5'd5, 32'h1234_5678, 32'h20, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 30'h0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 5'd5, 32'h1234_5678, 32'h0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 5'd3, 32'h8000_0000, 1'b1, 1'b0, 30'h0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b1, 5'd3, 32'h1, 32'h8, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 30'h100, 1'b0, 5'd0, 1'b0, 32'h0, 1'b1, 5'd31, 32'h400, 32'h8000_0000, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 30'h0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 5'd31, 32'h400, 32'h0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 5'd4, 32'h5, 1'b0, 1'b1, 30'h3, 1'b0, 5'd0, 1'b0, 32'h0, 1'b1, 5'd31, 32'hC, 32'h8000_0000, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 30'h0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 5'd31, 32'hC, 32'h0, 1'b0, 1'b1};
`else
    tbl[0]  = '{1'b1, 5'd5, 32'h1234_5678, 1'b0, 1'b0, 30'h0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h20, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 30'h0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b1, 5'd5, 32'h1234_5678, 32'h20, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 5'd3, 32'h8000_0000, 1'b1, 1'b0, 30'h0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 5'd5, 32'h1234_5678, 32'h8, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 30'h100, 1'b0, 5'd0, 1'b0, 32'h0, 1'b1, 5'd3, 32'h1, 32'h8000_0008, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 30'h0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b1, 5'd31, 32'h400, 32'h8000_0000, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 5'd4, 32'h5, 1'b0, 1'b1, 30'h3, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 5'd9, 32'h99, 32'h8000_0000, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 30'h0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b1, 5'd31, 32'hC, 32'h8000_0000, 1'b0, 1'b1};
`endif
    tbl[5]  = '{1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 30'h0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 5'd31, 32'h400, 32'h0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 30'h0, 1'b1, 5'd7, 1'b0, 32'h0, 1'b0, 5'd31, 32'h400, 32'h80, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 5'd9, 32'h99, 1'b0, 1'b0, 30'h0, 1'b0, 5'd0, 1'b1, 32'hAA, 1'b1, 5'd7, 32'hAA, 32'h280, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 30'h0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b1, 5'd9, 32'h99, 32'h200, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 30'h0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 5'd9, 32'h99, 32'h0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 5'd0, 32'hDEAD, 1'b0, 1'b0, 30'h0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 5'd9, 32'h99, 32'h0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 30'h0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 5'd31, 32'hC, 32'h0, 1'b0, 1'b1};

    clr_in();
    model_reset();
    do_reset();

    for (int i = 0; i < 14; i++) begin
      alu_valid = tbl[i].alu_v; alu_reg = tbl[i].alu_r; alu_data = tbl[i].alu_d;
      alu_set = tbl[i].alu_s; jal_valid = tbl[i].jal_v; pc_plus = tbl[i].pc;
      ld_issue = tbl[i].ld_i; ld_reg = tbl[i].ld_r;
      ld_resp_valid = tbl[i].ld_rv; ld_resp_data = tbl[i].ld_d;
      model_step();
      @(posedge clk);
      #1;
      chk($sformatf("row%0d_wr_en", i),   32'(wr_en),  32'(tbl[i].e_en));
      chk($sformatf("row%0d_wr_reg", i),  32'(wr_reg), 32'(tbl[i].e_reg));
      chk($sformatf("row%0d_wr_data", i), wr_data,     tbl[i].e_data);
      chk($sformatf("row%0d_pending", i), pending,     tbl[i].e_pend);
      chk($sformatf("row%0d_stall", i),   32'(stall),  32'(tbl[i].e_stall));
      chk($sformatf("row%0d_err", i),     32'(err),    32'(tbl[i].e_err));
    end
    clr_in();

    // Overflow: loads hold the port every cycle while five ALU requests arrive.
    do_reset();
    ld_issue = 1; ld_reg = 5'd20;
    step_chk();
    for (int i = 1; i <= 5; i++) begin
      ld_issue = 1; ld_reg = 5'(20 + i);
      ld_resp_valid = 1; ld_resp_data = 32'(i);
      alu_valid = 1; alu_reg = 5'(10 + i); alu_data = 32'h100 + 32'(i);
      step_chk();
      chk($sformatf("ovf_ld_wr_reg%0d", i), 32'(wr_reg), 32'(19 + i));
      if (i == 2) chk("ovf_stall_at2", 32'(stall), 32'h0);
      if (i == 3) chk("ovf_stall_at3", 32'(stall), 32'h1);
      if (i == 4) chk("ovf_err_at4", 32'(err), 32'h0);
      if (i == 5) chk("ovf_err_at5", 32'(err), 32'h1);
    end
    clr_in();
    ld_resp_valid = 1; ld_resp_data = 32'h55;
    step_chk();
    chk("ovf_last_ld", 32'(wr_reg), 32'd25);
    clr_in();
    for (int i = 1; i <= 4; i++) begin
      step_chk();
      chk($sformatf("ovf_drain%0d_reg", i), 32'(wr_reg), 32'(10 + i));
      chk($sformatf("ovf_drain%0d_data", i), wr_data, 32'h100 + 32'(i));
    end
    step_chk();
    chk("ovf_idle_wr_en", 32'(wr_en), 32'h0);

    // Reset mid-stream with three queued entries and err already set.
    do_reset();
    ld_issue = 1; ld_reg = 5'd20;
    step_chk();
    for (int i = 1; i <= 3; i++) begin
      ld_issue = 1; ld_reg = 5'(20 + i);
      ld_resp_valid = 1; ld_resp_data = 32'(i);
      alu_valid = 1; alu_reg = 5'(10 + i); alu_data = 32'(i);
      jal_valid = (i == 1); pc_plus = 30'h5;
      step_chk();
    end
    clr_in();
    chk("mid_pre_stall", 32'(stall), 32'h1);
    chk("mid_pre_err", 32'(err), 32'h1);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step_chk();
      chk("mid_post_wr_en", 32'(wr_en), 32'h0);
    end

    // Protocol errors and register-0 load tags.
    do_reset();
    ld_resp_valid = 1; ld_resp_data = 32'h77;
    step_chk();
    chk("resp_empty_err", 32'(err), 32'h1);
    chk("resp_empty_wr_en", 32'(wr_en), 32'h0);
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      clr_in(); ld_issue = 1; ld_reg = 5'(i);
      step_chk();
    end
    chk("tag_ovf_err", 32'(err), 32'h1);
    chk("tag_ovf_pending", pending, 32'h6);
    clr_in(); ld_resp_valid = 1; ld_resp_data = 32'hA1;
    step_chk();
    clr_in(); ld_resp_valid = 1; ld_resp_data = 32'hA2; ld_issue = 1; ld_reg = 5'd0;
    step_chk();
    chk("tag_second_reg", 32'(wr_reg), 32'd2);
    clr_in(); ld_resp_valid = 1; ld_resp_data = 32'hA3;
    step_chk();
    chk("tag_reg0_no_write", 32'(wr_en), 32'h0);
    chk("tag_reg0_pending", pending, 32'h0);
    clr_in();

    // Randomized traffic; first block avoids protocol errors so err stays meaningful.
    for (int blk = 0; blk < 3; blk++) begin
      do_reset();
      for (int c = 0; c < 600; c++) begin
        rand_inputs(blk == 0 ? 0 : 3);
        step_chk();
      end
    end
    clr_in();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
